// File: rtl/synth_reset_ctrl_if.sv
// Button/PLL inputs and synthesizer reset/status outputs of synth_reset_ctrl.
// The master side drives the raw inputs; the slave side is the controller.
interface synth_reset_ctrl_if #(
    parameter int unsigned NBTN = 3
);
    logic [NBTN-1:0] btn_n;
    logic            pll_locked;
    logic            synth_rst_n;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_press;
    logic            por_done;
    logic [7:0]      soft_rst_cnt;
    logic [1:0]      state;

    modport master (
        output btn_n,
        output pll_locked,
        input  synth_rst_n,
        input  btn_level,
        input  btn_press,
        input  por_done,
        input  soft_rst_cnt,
        input  state
    );

    modport slave (
        input  btn_n,
        input  pll_locked,
        output synth_rst_n,
        output btn_level,
        output btn_press,
        output por_done,
        output soft_rst_cnt,
        output state
    );
endinterface

// File: rtl/synth_reset_ctrl.sv
// Synthesizer reset front-end: PLL-gated power-on sequence, debounced buttons
// with press strobes, and a soft-reset button that pulses synth_rst_n low.
module synth_reset_ctrl #(
    parameter int unsigned NBTN       = 3,
    parameter int unsigned POR_CYCLES = 200,
    parameter int unsigned DEB_CYCLES = 64,
    parameter int unsigned RST_PULSE  = 16
) (
    input  logic              sysclk,
    input  logic              reset1,
    synth_reset_ctrl_if.slave bus
);

    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int unsigned PUL_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
    localparam logic [POR_W-1:0] POR_MAX = POR_W'(POR_CYCLES - 1);
    localparam logic [PUL_W-1:0] PUL_MAX = PUL_W'(RST_PULSE - 1);

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_RUN  = 2'd1,
        ST_SOFT = 2'd2
    } state_e;

    logic [NBTN-1:0]            btn_meta_q;
    logic [NBTN-1:0]            btn_sync_q;
    logic                       lock_meta_q;
    logic                       lock_sync_q;

    logic [NBTN-1:0][DEB_W-1:0] deb_cnt_q;
    logic [NBTN-1:0][DEB_W-1:0] deb_cnt_d;
    logic [NBTN-1:0]            btn_level_q;
    logic [NBTN-1:0]            btn_level_d;
    logic [NBTN-1:0]            btn_press_q;
    logic [NBTN-1:0]            btn_press_d;
    logic [NBTN-1:0]            pressed;

    state_e                     state_q;
    state_e                     state_d;
    logic [POR_W-1:0]           por_cnt_q;
    logic [POR_W-1:0]           por_cnt_d;
    logic [PUL_W-1:0]           pulse_cnt_q;
    logic [PUL_W-1:0]           pulse_cnt_d;
    logic                       por_done_q;
    logic                       por_done_d;
    logic [7:0]                 soft_cnt_q;
    logic [7:0]                 soft_cnt_d;
    logic                       synth_rst_n_q;
    logic                       synth_rst_n_d;

    // Synchronisers idle at "button released, PLL unlocked".
    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            btn_meta_q  <= '1;
            btn_sync_q  <= '1;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            btn_meta_q  <= bus.btn_n;
            btn_sync_q  <= btn_meta_q;
            lock_meta_q <= bus.pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    always_comb begin
        pressed     = ~btn_sync_q;
        deb_cnt_d   = '0;
        btn_level_d = btn_level_q;
        for (int unsigned i = 0; i < NBTN; i++) begin
            if (pressed[i] != btn_level_q[i]) begin
                if (deb_cnt_q[i] == DEB_MAX) begin
                    btn_level_d[i] = ~btn_level_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
        btn_press_d = btn_level_d & ~btn_level_q;
    end

    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            deb_cnt_q   <= '0;
            btn_level_q <= '0;
            btn_press_q <= '0;
        end else begin
            deb_cnt_q   <= deb_cnt_d;
            btn_level_q <= btn_level_d;
            btn_press_q <= btn_press_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        por_cnt_d   = por_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        por_done_d  = por_done_q;
        soft_cnt_d  = soft_cnt_q;

        case (state_q)
            ST_POR: begin
                if (!lock_sync_q) begin
                    por_cnt_d = '0;
                end else if (por_cnt_q == POR_MAX) begin
                    state_d    = ST_RUN;
                    por_cnt_d  = '0;
                    por_done_d = 1'b1;
                end else begin
                    por_cnt_d = por_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_sync_q) begin
                    state_d   = ST_POR;
                    por_cnt_d = '0;
                end else if (btn_press_q[0]) begin
                    state_d     = ST_SOFT;
                    pulse_cnt_d = '0;
                    if (soft_cnt_q != 8'hFF) begin
                        soft_cnt_d = soft_cnt_q + 8'd1;
                    end
                end
            end
            ST_SOFT: begin
                // Pulse counter parks at its maximum so a held button extends the reset.
                if (!lock_sync_q) begin
                    state_d   = ST_POR;
                    por_cnt_d = '0;
                end else if (pulse_cnt_q == PUL_MAX) begin
                    if (!btn_level_q[0]) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_POR;
                por_cnt_d = '0;
            end
        endcase

        synth_rst_n_d = (state_d == ST_RUN);
    end

    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            state_q       <= ST_POR;
            por_cnt_q     <= '0;
            pulse_cnt_q   <= '0;
            por_done_q    <= 1'b0;
            soft_cnt_q    <= '0;
            synth_rst_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            por_cnt_q     <= por_cnt_d;
            pulse_cnt_q   <= pulse_cnt_d;
            por_done_q    <= por_done_d;
            soft_cnt_q    <= soft_cnt_d;
            synth_rst_n_q <= synth_rst_n_d;
        end
    end

    assign bus.synth_rst_n  = synth_rst_n_q;
    assign bus.btn_level    = btn_level_q;
    assign bus.btn_press    = btn_press_q;
    assign bus.por_done     = por_done_q;
    assign bus.soft_rst_cnt = soft_cnt_q;
    assign bus.state        = state_q;

endmodule
